usb_uart_tx_arbiter: RTL and testbench
======================================

Name: usb_uart_tx_arbiter

Overview:
- Shares the single host-bound byte pipeline of the USB serial core (uart_in_data / uart_in_valid / uart_in_ready) between NUM_REQ independent byte-stream requesters, for example the Forth console and a debug/trace source.
- Grants are line-atomic: once a requester owns the pipe, it keeps it until it sends an end-of-line byte, reaches a burst limit, or stalls for too long. This stops host-side text from interleaving mid-line.
- Sits between the requesters and the uart_in side of the usb_uart wrapper, in the clk_48mhz domain.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_BURST, 64, bytes accepted per grant before forced release (1..255).
- EOL_CHAR, 8'h0A, byte value whose acceptance releases the grant.
- IDLE_TIMEOUT, 255, consecutive cycles with granted req_valid low before forced release (1..65535).

Ports:
- clk_48mhz  input  1  system clock, 48 MHz.
- reset_n  input  1  synchronous, active-low reset.
- req_data  input  8*NUM_REQ  requester bytes; requester i uses bits [8i+7:8i].
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_ready  output  NUM_REQ  per-requester accept.
- uart_in_data  output  8  to the usb_uart uart_in_data port.
- uart_in_valid  output  1  to the usb_uart uart_in_valid port.
- uart_in_ready  input  1  from the usb_uart uart_in_ready port.
- grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
- busy  output  1  high while in LOCKED state.

Behaviour:
- Reset (reset_n low at a clock edge):
  - state IDLE, grant=0, busy=0, burst counter=0, timeout counter=0.
  - Round-robin pointer set to requester 0.
  - uart_in_valid=0, req_ready=0, uart_in_data=0.
- Reset mid-transfer aborts the grant immediately. The byte on the bus that cycle is not considered transferred.
- States: IDLE and LOCKED.
- IDLE:
  - grant=0; all req_ready=0; uart_in_valid=0.
  - If any req_valid is high, pick the first valid requester searching from the pointer upward with wrap-around.
  - Next cycle: grant=one-hot(winner), state LOCKED, counters cleared.
  - Arbitration costs exactly one cycle. A byte presented in IDLE is transferred no earlier than the following cycle.
- LOCKED, with g the owner:
  - Datapath is combinational: uart_in_data=req_data[g], uart_in_valid=req_valid[g], req_ready[g]=uart_in_ready. All other req_ready=0.
  - Transfer occurs when uart_in_valid and uart_in_ready are both high. Each transfer increments the 8-bit burst counter.
- Release from LOCKED. On any release cause: next cycle state IDLE, grant=0, pointer=(g+1) mod NUM_REQ.
  - A transfer whose byte equals EOL_CHAR.
  - A transfer that brings the burst counter to MAX_BURST.
  - The timeout counter reaching IDLE_TIMEOUT. This counter increments each LOCKED cycle with req_valid[g] low and clears on any cycle with req_valid[g] high. Back-pressure (valid high, ready low) never times out.
- If EOL and MAX_BURST coincide on the same transfer: a single release, same behaviour.
- Valid held through release: the owner's byte after a release is not accepted that cycle. After the one-cycle IDLE it re-arbitrates with rotated priority, so another waiting requester wins first.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- busy equals (state==LOCKED).

Optional Feature:
- Macro USB_ARB_PRIO_EN.
- Defined: requester 0 is strict priority at every IDLE arbitration. If req_valid[0] is high it wins regardless of the pointer. The pointer rotates only among requesters 1..NUM_REQ-1. Grants are still never pre-empted mid-line.
- Undefined: pure round-robin as above.

Test Plan:
- Single requester: req0 sends "OK\n" (0x4F,0x4B,0x0A) with uart_in_ready=1 -> grant=01 one cycle after req_valid rises; three transfers; grant=00 the cycle after 0x0A; pointer=1.
- Two contenders: req0 sends "AB\n", req1 sends "CD\n", both valid at cycle 0 -> host receives 41,42,0A,43,44,0A with no interleave; one idle cycle between lines.
- Burst limit, MAX_BURST=4: req1 streams 0x30..0x39 with no EOL while req0 is valid -> 30..33 from req1, then req0's line, then req1 resumes at 34.
- Timeout, IDLE_TIMEOUT=8: req0 sends one byte then drops valid -> release exactly 8 cycles after the last req_valid high; uart_in_ready held low for 100 cycles with valid high -> no release.
- Reset mid-line: reset_n low for 1 cycle after the 2nd byte of a 5-byte line -> next cycle grant=0, uart_in_valid=0, req_ready=0; arbitration restarts at req0.
- With USB_ARB_PRIO_EN: req1 and req2 mid-rotation, req0 asserts valid -> req0 granted at the next release point; the current line is not pre-empted.

Source files
------------

// File: rtl/usb_uart_tx_arbiter.sv
// Line-atomic round-robin arbiter sharing the usb_uart uart_in byte pipe between NUM_REQ sources.
// Optional macro USB_ARB_PRIO_EN: requester 0 wins every arbitration it takes part in.
module usb_uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned MAX_BURST    = 64,
    parameter logic [7:0]  EOL_CHAR     = 8'h0A,
    parameter int unsigned IDLE_TIMEOUT = 255
) (
    input  logic                 clk_48mhz,
    input  logic                 reset_n,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_in_data,
    output logic                 uart_in_valid,
    input  logic                 uart_in_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e          state_q;
    logic [IdxW-1:0] owner_q;
    logic [IdxW-1:0] ptr_q;
    logic [7:0]      burst_q;
    logic [15:0]     idle_q;

    logic            win_valid;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] rel_ptr;
    logic            xfer;
    logic            rel;
`ifdef USB_ARB_PRIO_EN
    int unsigned     base;
`endif

    always_comb begin
        uart_in_data  = '0;
        uart_in_valid = 1'b0;
        req_ready     = '0;
        if (state_q == StLocked) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (owner_q == IdxW'(i)) begin
                    uart_in_data  = req_data[8*i +: 8];
                    uart_in_valid = req_valid[i];
                    req_ready[i]  = uart_in_ready;
                end
            end
        end
    end

    assign xfer = uart_in_valid && uart_in_ready;
    assign rel  = (xfer && ((uart_in_data == EOL_CHAR) ||
                            ({1'b0, burst_q} + 9'd1 == 9'(MAX_BURST)))) ||
                  (!uart_in_valid && ({1'b0, idle_q} + 17'd1 == 17'(IDLE_TIMEOUT)));

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef USB_ARB_PRIO_EN
        // Requester 0 bypasses the pointer; the pointer only walks 1..NUM_REQ-1.
        base = (ptr_q == '0) ? 0 : 32'(ptr_q) - 1;
        if (req_valid[0]) begin
            win_valid = 1'b1;
        end
        for (int unsigned k = 0; k < NUM_REQ - 1; k++) begin
            cand = IdxW'(1 + ((base + k) % (NUM_REQ - 1)));
            if (!win_valid && req_valid[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
`else
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % NUM_REQ);
            if (!win_valid && req_valid[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    always_comb begin
`ifdef USB_ARB_PRIO_EN
        if (owner_q == '0) begin
            rel_ptr = ptr_q;
        end else if (32'(owner_q) + 1 >= NUM_REQ) begin
            rel_ptr = IdxW'(1);
        end else begin
            rel_ptr = owner_q + IdxW'(1);
        end
`else
        if (32'(owner_q) + 1 >= NUM_REQ) begin
            rel_ptr = '0;
        end else begin
            rel_ptr = owner_q + IdxW'(1);
        end
`endif
    end

    always_ff @(posedge clk_48mhz) begin
        if (!reset_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            idle_q  <= '0;
            grant   <= '0;
            busy    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        state_q <= StLocked;
                        owner_q <= win_idx;
                        grant   <= NUM_REQ'(1) << win_idx;
                        busy    <= 1'b1;
                        burst_q <= '0;
                        idle_q  <= '0;
                    end
                end
                StLocked: begin
                    if (rel) begin
                        state_q <= StIdle;
                        grant   <= '0;
                        busy    <= 1'b0;
                        ptr_q   <= rel_ptr;
                        burst_q <= '0;
                        idle_q  <= '0;
                    end else begin
                        if (xfer) begin
                            burst_q <= burst_q + 8'd1;
                        end
                        // Back-pressure keeps valid high, so it never advances the timeout.
                        idle_q <= uart_in_valid ? 16'd0 : idle_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// Self-checking bench for usb_uart_tx_arbiter: directed line scenarios plus a randomized run
// against a queue-based reference model of the arbitration rules.
module tb_usb_uart_tx_arbiter;
    localparam int NREQ = 3;
    localparam int MAXB = 4;
    localparam int TMO  = 8;
    localparam logic [7:0] EOL = 8'h0A;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NREQ-1:0][7:0] reqd;
    logic [NREQ-1:0]      reqv;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      grant;
    logic [7:0]           uart_in_data;
    logic                 uart_in_valid;
    logic                 uart_in_ready;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    byte unsigned sq[NREQ][$];
    int           start_at[NREQ];
    byte unsigned got[$];
    int           got_cyc[$];

    always #5 clk = ~clk;

    usb_uart_tx_arbiter #(
        .NUM_REQ     (NREQ),
        .MAX_BURST   (MAXB),
        .EOL_CHAR    (EOL),
        .IDLE_TIMEOUT(TMO)
    ) dut (
        .clk_48mhz    (clk),
        .reset_n      (reset_n),
        .req_data     (reqd),
        .req_valid    (reqv),
        .req_ready    (req_ready),
        .uart_in_data (uart_in_data),
        .uart_in_valid(uart_in_valid),
        .uart_in_ready(uart_in_ready),
        .grant        (grant),
        .busy         (busy)
    );

    function automatic int pick(logic [NREQ-1:0] v, int p);
`ifdef USB_ARB_PRIO_EN
        int b;
        if (v[0]) return 0;
        b = (p == 0) ? 0 : p - 1;
        for (int k = 0; k < NREQ - 1; k++) begin
            if (v[1 + ((b + k) % (NREQ - 1))]) return 1 + ((b + k) % (NREQ - 1));
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
`endif
        return -1;
    endfunction

    function automatic int next_ptr(int g, int p);
`ifdef USB_ARB_PRIO_EN
        if (g == 0) return p;
        return (g + 1 >= NREQ) ? 1 : g + 1;
`else
        if (p < 0) return 0;
        return (g + 1) % NREQ;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        reqv = '0;
        reqd = '0;
        uart_in_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drives each queued stream on valid/ready and records what the host side accepts.
    task automatic run_streams(int ncyc);
        got.delete();
        got_cyc.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (c >= start_at[i] && sq[i].size() > 0) begin
                    reqv[i] = 1'b1;
                    reqd[i] = sq[i][0];
                end else begin
                    reqv[i] = 1'b0;
                    reqd[i] = 8'h00;
                end
            end
            uart_in_ready = 1'b1;
            #1;
            if (uart_in_valid && uart_in_ready) begin
                got.push_back(uart_in_data);
                got_cyc.push_back(c);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (reqv[i] && req_ready[i]) void'(sq[i].pop_front());
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        reqv = '1;
        reqd = {8'h11, 8'h22, 8'h33};
        uart_in_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b want 000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (uart_in_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", uart_in_valid); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        checks++; if (uart_in_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", uart_in_data); end
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL reset_first_grant: got %b want 001", grant); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy: got %b want 1", busy); end
        checks++; if (uart_in_data !== 8'h33) begin errors++; $display("FAIL reset_first_data: got %h want 33", uart_in_data); end
    endtask

    task automatic test_single_line();
        byte unsigned line[3] = '{8'h4F, 8'h4B, 8'h0A};
        do_reset();
        @(negedge clk);
        reqv = 3'b001;
        reqd[0] = line[0];
        uart_in_ready = 1'b1;
        #1;
        checks++; if (grant !== 3'b000 || uart_in_valid !== 1'b0) begin
            errors++; $display("FAIL single_arb_cycle: got grant=%b valid=%b want 000/0", grant, uart_in_valid);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            reqd[0] = line[k];
            #1;
            checks++; if (grant !== 3'b001 || req_ready !== 3'b001) begin
                errors++; $display("FAIL single_grant[%0d]: got grant=%b ready=%b want 001/001", k, grant, req_ready);
            end
            checks++; if (uart_in_valid !== 1'b1 || uart_in_data !== line[k]) begin
                errors++; $display("FAIL single_data[%0d]: got %b/%h want 1/%h", k, uart_in_valid, uart_in_data, line[k]);
            end
        end
        @(negedge clk);
        reqv = 3'b000;
        #1;
        checks++; if (grant !== 3'b000 || busy !== 1'b0) begin
            errors++; $display("FAIL single_release: got grant=%b busy=%b want 000/0", grant, busy);
        end
        // Pointer has moved to 1, so req1 beats req0.
        @(negedge clk);
        reqv = 3'b011;
        reqd[0] = 8'h11;
        reqd[1] = EOL;
        #1;
        @(negedge clk);
        #1;
        checks++; if (grant !== 3'b010) begin errors++; $display("FAIL single_ptr: got %b want 010", grant); end
        @(negedge clk);
        reqv = 3'b000;
    endtask

    task automatic test_two_contenders();
        byte unsigned a[3] = '{8'h41, 8'h42, 8'h0A};
        byte unsigned b[3] = '{8'h43, 8'h44, 8'h0A};
        byte unsigned exp_b[6] = '{8'h41, 8'h42, 8'h0A, 8'h43, 8'h44, 8'h0A};
        int exp_c[6] = '{1, 2, 3, 5, 6, 7};
        do_reset();
        for (int i = 0; i < NREQ; i++) begin sq[i].delete(); start_at[i] = 0; end
        foreach (a[k]) sq[0].push_back(a[k]);
        foreach (b[k]) sq[1].push_back(b[k]);
        run_streams(12);
        checks++; if (got.size() !== 6) begin errors++; $display("FAIL two_count: got %0d want 6", got.size()); end
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            checks++; if (got[k] !== exp_b[k] || got_cyc[k] !== exp_c[k]) begin
                errors++; $display("FAIL two_byte[%0d]: got %h@%0d want %h@%0d", k, got[k], got_cyc[k], exp_b[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_burst_limit();
        byte unsigned exp_b[12] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h5A, 8'h0A,
                                    8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        int exp_c[12] = '{1, 2, 3, 4, 6, 7, 9, 10, 11, 12, 14, 15};
        do_reset();
        for (int i = 0; i < NREQ; i++) begin sq[i].delete(); start_at[i] = 0; end
        for (int k = 0; k < 10; k++) sq[1].push_back(8'(8'h30 + k));
        sq[0].push_back(8'h5A);
        sq[0].push_back(EOL);
        start_at[0] = 2;
        run_streams(30);
        checks++; if (got.size() !== 12) begin errors++; $display("FAIL burst_count: got %0d want 12", got.size()); end
        for (int k = 0; k < 12 && k < got.size(); k++) begin
            checks++; if (got[k] !== exp_b[k] || got_cyc[k] !== exp_c[k]) begin
                errors++; $display("FAIL burst_byte[%0d]: got %h@%0d want %h@%0d", k, got[k], got_cyc[k], exp_b[k], exp_c[k]);
            end
        end
        // req1's tail has no EOL, so only the idle timeout frees the pipe.
        checks++; if (grant !== 3'b000 || busy !== 1'b0) begin
            errors++; $display("FAIL burst_tail_timeout: got grant=%b busy=%b want 000/0", grant, busy);
        end
    endtask

    task automatic test_timeout();
        int held = 0;
        do_reset();
        @(negedge clk);
        reqv = 3'b001;
        reqd[0] = 8'h55;
        uart_in_ready = 1'b1;
        #1;
        @(negedge clk);
        #1;
        checks++; if (grant !== 3'b001 || uart_in_valid !== 1'b1) begin
            errors++; $display("FAIL tmo_first: got grant=%b valid=%b want 001/1", grant, uart_in_valid);
        end
        // Eight low-valid cycles while locked, then the grant drops.
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            reqv = 3'b000;
            #1;
            checks++; if (grant !== 3'b001) begin errors++; $display("FAIL tmo_hold[%0d]: got %b want 001", k, grant); end
        end
        @(negedge clk);
        #1;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL tmo_release: got %b want 000", grant); end
        @(negedge clk);
        reqv = 3'b001;
        reqd[0] = 8'h66;
        uart_in_ready = 1'b0;
        #1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (grant === 3'b001 && uart_in_valid === 1'b1 && busy === 1'b1) held++;
        end
        checks++; if (held !== 100) begin errors++; $display("FAIL bp_hold: got %0d want 100 locked cycles", held); end
        @(negedge clk);
        reqd[0] = EOL;
        uart_in_ready = 1'b1;
        #1;
        @(negedge clk);
        reqv = 3'b000;
        #1;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL bp_release: got %b want 000", grant); end
    endtask

    task automatic test_reset_midline();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin sq[i].delete(); start_at[i] = 0; end
        sq[0].push_back(8'h78);
        sq[0].push_back(EOL);
        run_streams(4);
        @(negedge clk);
        reqv = 3'b010;
        reqd[1] = 8'h48;
        #1;
        @(negedge clk);
        #1;
        @(negedge clk);
        reqd[1] = 8'h45;
        #1;
        @(negedge clk);
        reqd[1] = 8'h4C;
        reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        reqv = 3'b011;
        reqd[0] = EOL;
        #1;
        checks++; if (grant !== 3'b000 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid_grant: got grant=%b busy=%b want 000/0", grant, busy);
        end
        checks++; if (uart_in_valid !== 1'b0 || req_ready !== 3'b000) begin
            errors++; $display("FAIL rst_mid_bus: got valid=%b ready=%b want 0/000", uart_in_valid, req_ready);
        end
        @(negedge clk);
        #1;
        checks++; if (grant !== 3'b001) begin errors++; $display("FAIL rst_mid_restart: got %b want 001", grant); end
        @(negedge clk);
        reqv = 3'b000;
    endtask

    task automatic test_random();
        byte unsigned q[NREQ][$];
        int lowrun[NREQ];
        int owner = -1, ptr = 0, cnt = 0, low = 0, nxt, left = 0, len;
        byte unsigned b;
        bit rel;
        logic [NREQ-1:0] exp_grant, exp_rr;
        for (int i = 0; i < NREQ; i++) begin
            lowrun[i] = 0;
            for (int l = 0; l < 6; l++) begin
                len = $urandom_range(1, 7);
                for (int k = 0; k < len - 1; k++) q[i].push_back(8'($urandom_range(32, 126)));
                q[i].push_back(EOL);
            end
        end
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            left = 0;
            for (int i = 0; i < NREQ; i++) left += q[i].size();
            if (left == 0 && owner < 0) break;
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (q[i].size() > 0 && (lowrun[i] >= 3 || $urandom_range(0, 3) != 0)) begin
                    reqv[i] = 1'b1;
                    reqd[i] = q[i][0];
                    lowrun[i] = 0;
                end else begin
                    reqv[i] = 1'b0;
                    reqd[i] = 8'($urandom);
                    lowrun[i]++;
                end
            end
            uart_in_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_grant = (owner < 0) ? '0 : (NREQ'(1) << owner);
            checks++; if (grant !== exp_grant || busy !== (owner >= 0)) begin
                errors++; $display("FAIL rand_grant@%0d: got %b/%b want %b", c, grant, busy, exp_grant);
            end
            if (owner >= 0) begin
                exp_rr = uart_in_ready ? (NREQ'(1) << owner) : '0;
                checks++; if (uart_in_valid !== reqv[owner] || uart_in_data !== reqd[owner]) begin
                    errors++; $display("FAIL rand_bus@%0d: got %b/%h want %b/%h", c, uart_in_valid, uart_in_data, reqv[owner], reqd[owner]);
                end
                checks++; if (req_ready !== exp_rr) begin
                    errors++; $display("FAIL rand_ready@%0d: got %b want %b", c, req_ready, exp_rr);
                end
            end else begin
                checks++; if (uart_in_valid !== 1'b0 || req_ready !== '0) begin
                    errors++; $display("FAIL rand_idle_bus@%0d: got %b/%b want 0/000", c, uart_in_valid, req_ready);
                end
            end
            nxt = owner;
            rel = 1'b0;
            if (owner >= 0) begin
                if (reqv[owner] && uart_in_ready) begin
                    b = q[owner].pop_front();
                    cnt++;
                    low = 0;
                    rel = (b == EOL) || (cnt == MAXB);
                end else if (!reqv[owner]) begin
                    low++;
                    rel = (low == TMO);
                end else begin
                    low = 0;
                end
                if (rel) begin
                    ptr = next_ptr(owner, ptr);
                    nxt = -1;
                end
            end else begin
                nxt = pick(reqv, ptr);
                cnt = 0;
                low = 0;
            end
            owner = nxt;
        end
        checks++; if (left !== 0 || owner >= 0) begin
            errors++; $display("FAIL rand_drain: got %0d bytes left owner %0d want 0/-1", left, owner);
        end
        @(negedge clk);
        reqv = '0;
    endtask

    initial begin
        reqv = '0;
        reqd = '0;
        uart_in_ready = 1'b0;
        test_reset();
        test_single_line();
        test_two_contenders();
        test_burst_limit();
        test_timeout();
        test_reset_midline();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
